// File: rtl/shift_unit_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_unit_pkg;

  // Shift operation codes, as driven by the control unit.
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Shifter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit_step.sv
// Single-position shift step: combinational, one bit per evaluation.
module shift_step
  import shift_unit_pkg::*;
(
  input  logic [31:0] x,
  input  logic [1:0]  op,
  output logic [31:0] y
);

  // Select the one-bit move for the requested operation.
  always_comb begin
    y = x;
    case (op)
      SH_SLL:  y = {x[30:0], 1'b0};
      SH_SRL:  y = {1'b0, x[31:1]};
      SH_SRA:  y = {x[31], x[31:1]};
      SH_ROR:  y = {x[0], x[31:1]};
      default: y = x;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Iterative 32-bit shifter: SLL/SRL/SRA/ROR, one bit per clock.
//
// Handshake: start is a request sampled only while in IDLE; the operands
// (shift_in, shift_op, n) are captured on that edge and may change freely
// afterwards. busy is high exactly while shifting, done pulses for exactly
// one cycle when shift_out holds the result. start seen outside IDLE is
// dropped, never queued. shift_out keeps the result until the next accepted
// start.
module shift_unit
  import shift_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  shift_op,
  input  logic [31:0] shift_in,
  input  logic [4:0]  n,
  output logic [31:0] shift_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_shift;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] w_step;

  shift_step u_step (
    .x  (r_shift),
    .op (r_op),
    .y  (w_step)
  );

  // State register; reset overrides any pending transition, including DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. A zero shift amount skips SHIFT entirely; cnt==1 marks
  // the last step. The cnt==0 case in SHIFT cannot occur but exits safely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (n != 5'd0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt <= 5'd1) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on an accepted start, then step and count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= 32'd0;
      r_cnt   <= 5'd0;
      r_op    <= SH_SLL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift <= shift_in;
            r_op    <= shift_op;
            r_cnt   <= n;
          end
        end
        ST_SHIFT: begin
          r_shift <= w_step;
          if (r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: begin
          r_shift <= r_shift;
        end
      endcase
    end
  end

  // Outputs are pure state decodes so they never depend on inputs directly.
  always_comb begin
    busy      = (r_state == ST_SHIFT);
    done      = (r_state == ST_DONE);
    shift_out = r_shift;
    state_dbg = r_state;
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed testbench for shift_unit with hand-computed expected results.
module tb_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  shift_op;
  logic [31:0] shift_in;
  logic [4:0]  n;
  logic [31:0] shift_out;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  shift_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shift_op  (shift_op),
    .shift_in  (shift_in),
    .n         (n),
    .shift_out (shift_out),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: issue one op, measure latency and busy cycles, check result via
  // the expected queue. With disturb set, new inputs and a start pulse are
  // thrown at the unit while it shifts; they must be ignored.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] din,
                        input logic [4:0] nn, input logic [31:0] exp, input bit disturb);
    int lat;
    int nb;
    logic [31:0] want;
    exp_q.push_back(exp);
    shift_op = op;
    shift_in = din;
    n        = nn;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    nb  = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      if (disturb && lat == 2) begin
        start    = 1'b1;
        shift_in = 32'hDEAD_BEEF;
        n        = 5'd3;
        shift_op = ~op;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(nn) + 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(nn));
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_result"}, shift_out, want);
    tick();
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_result"}, shift_out, exp);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    shift_op = 2'b00;
    shift_in = 32'd0;
    n        = 5'd0;
    tick();
    tick();
    check("rst_shift_out", shift_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // Start together with reset: dropped.
    shift_in = 32'h0000_00FF;
    n        = 5'd2;
    start    = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (done || busy) seen++;
        tick();
      end
      check("rst_start_dropped", 32'(seen), 32'd0);
      check("rst_start_out", shift_out, 32'd0);
    end

    // Directed vectors
    run_op("sll4",   2'b00, 32'h0000_000F, 5'd4,  32'h0000_00F0, 1'b0);
    run_op("sra31",  2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    run_op("srl31",  2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    run_op("srl0",   2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
    run_op("ror8",   2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0);
    run_op("ror8_d", 2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (done || busy) seen++;
        tick();
      end
      check("no_second_done", 32'(seen), 32'd0);
      check("ror8_d_still", shift_out, 32'h7812_3456);
    end
    run_op("sra4",   2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0);
    run_op("ror31",  2'b11, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0);
    run_op("sll31",  2'b00, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0);
    run_op("sra1",   2'b10, 32'hF000_0001, 5'd1,  32'hF800_0000, 1'b0);

    // Reset mid-op: SLL n=20, reset sampled at E0+5.
    shift_op = 2'b00;
    shift_in = 32'h0000_0001;
    n        = 5'd20;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    check("mid_rst_out", shift_out, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        if (done || busy) seen++;
        tick();
      end
      check("mid_rst_no_done", 32'(seen), 32'd0);
    end
    run_op("fresh_sll20", 2'b00, 32'h0000_0001, 5'd20, 32'h0010_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
